// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory block-transfer arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;
  localparam int MAX_ADDR_W = 64;

  // Clears the byte-offset bits inside one block; block_width must be a power of two.
  function automatic logic [MAX_ADDR_W-1:0] block_align(input logic [MAX_ADDR_W-1:0] addr,
                                                        input int unsigned block_width);
    logic [MAX_ADDR_W-1:0] span;
    span = MAX_ADDR_W'(block_width / 8);
    return addr & ~(span - MAX_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/mem_req_arbiter_pick.sv
// Combinational requestor picker: rotate-mask priority encoder producing a
// one-hot grant and the matching binary index.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               mode_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int                 start;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] src;
  logic               found;

  always_comb begin
    start  = (int'(mode_i) == ARB_FIXED) ? 0 : int'(ptr_i);
    masked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req_i[i] && (i >= start);
    end
    // Wrap to the bottom of the vector when nothing sits at or above the pointer.
    src   = (|masked) ? masked : req_i;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src[i] && !found) begin
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mem_req_arbiter.sv
// Block-transfer arbiter: grants one cache requestor at a time to the AXI
// block engine and sequences the start/done handshake with a registered FSM.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int ARB_MODE    = 0
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ-1:0]             i_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*BLOCK_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]             o_req_done,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic [BLOCK_WIDTH-1:0]         o_rdata,
  input  logic                           i_axi_done,
  input  logic [BLOCK_WIDTH-1:0]         i_data_block,
  output logic [ADDR_WIDTH-1:0]          o_axi_addr,
  output logic [BLOCK_WIDTH-1:0]         o_data_block,
  output logic                           o_axi_read_start,
  output logic                           o_axi_write_start
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t             state_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [NUM_REQ-1:0]     done_q;
  logic                   we_q;
  logic                   rd_start_q;
  logic                   wr_start_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [BLOCK_WIDTH-1:0] wdata_q;
  logic [BLOCK_WIDTH-1:0] wdata_d;
  logic [BLOCK_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic                   we_d;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i  (i_req),
    .ptr_i  (rr_ptr_q),
    .mode_i (ARB_MODE == ARB_RR),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    addr_d  = ADDR_WIDTH'(block_align(
                MAX_ADDR_W'(i_req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH]), BLOCK_WIDTH));
    wdata_d = i_req_wdata[int'(pick_idx)*BLOCK_WIDTH +: BLOCK_WIDTH];
    we_d    = i_req_we[pick_idx];
  end

  // Pointer moves one past the winner so that requestor drops to lowest RR priority.
  assign rr_ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      we_q       <= 1'b0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_gnt;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_start_q <= we_d;
            rd_start_q <= ~we_d;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          rd_start_q <= 1'b0;
          wr_start_q <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (i_axi_done) begin
            if (!we_q) begin
              rdata_q <= i_data_block;
            end
            done_q  <= grant_q;
            state_q <= RESP;
          end
        end
        RESP: begin
          done_q  <= '0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_done        = done_q;
  assign o_grant           = grant_q;
  assign o_rdata           = rdata_q;
  assign o_axi_addr        = addr_q;
  assign o_data_block      = wdata_q;
  assign o_axi_read_start  = rd_start_q;
  assign o_axi_write_start = wr_start_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share one
// set of requestor/AXI stimulus; expected transactions are queued up front.
module tb_mem_req_arbiter;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int BW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_wdata;
  logic          axi_done;
  logic [BW-1:0] data_block;

  logic [N-1:0]  f_done, f_grant, r_done, r_grant;
  logic [BW-1:0] f_rdata, f_wdata, r_rdata, r_wdata;
  logic [AW-1:0] f_addr, r_addr;
  logic          f_rs, f_ws, r_rs, r_ws;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [BW-1:0] exp_rd;

  typedef struct {
    logic [N-1:0]  gf;
    logic [N-1:0]  gr;
    logic          we;
    logic [AW-1:0] af;
    logic [AW-1:0] ar;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rd;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .ARB_MODE(0)) u_fix (
    .i_clk(clk), .i_arst(rst), .i_req(req), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_req_done(f_done), .o_grant(f_grant), .o_rdata(f_rdata),
    .i_axi_done(axi_done), .i_data_block(data_block), .o_axi_addr(f_addr),
    .o_data_block(f_wdata), .o_axi_read_start(f_rs), .o_axi_write_start(f_ws)
  );

  mem_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .ARB_MODE(1)) u_rr (
    .i_clk(clk), .i_arst(rst), .i_req(req), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_req_done(r_done), .o_grant(r_grant), .o_rdata(r_rdata),
    .i_axi_done(axi_done), .i_data_block(data_block), .o_axi_addr(r_addr),
    .o_data_block(r_wdata), .o_axi_read_start(r_rs), .o_axi_write_start(r_ws)
  );

  task automatic chk_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [BW-1:0] w);
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*BW +: BW] = w;
  endtask

  function automatic logic [AW-1:0] slot_addr(input logic [N-1:0] oh);
    logic [AW-1:0] a;
    a = '0;
    for (int k = 0; k < N; k++) if (oh[k]) a = req_addr[k*AW +: AW] & ~64'h3F;
    return a;
  endfunction

  task automatic push_exp(input logic [N-1:0] gf, input logic [N-1:0] gr, input logic we,
                          input logic [AW-1:0] af, input logic [AW-1:0] ar,
                          input logic [BW-1:0] wdata, input logic [BW-1:0] rd);
    exp_t e;
    e.gf = gf; e.gr = gr; e.we = we; e.af = af; e.ar = ar; e.wdata = wdata; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk_val({tag, "_grant"}, {f_grant, r_grant}, '0);
    chk_val({tag, "_done"}, {f_done, r_done}, '0);
    chk_val({tag, "_start"}, {f_rs, f_ws, r_rs, r_ws}, '0);
    chk_val({tag, "_addr"}, f_addr | r_addr, '0);
    chk_val({tag, "_wdata"}, f_wdata | r_wdata, '0);
    chk_val({tag, "_rdata"}, f_rdata | r_rdata, '0);
  endtask

  // Plays the AXI engine for one transaction and checks both instances against the queue head.
  task automatic serve(input int lat, input logic [N-1:0] clr_mask, input logic [N-1:0] set_mid,
                       input bit early_done, input bit scramble, output int t_start, output int t_done);
    exp_t e;
    int   n;
    n = 0;
    t_start = -1;
    t_done  = -1;
    while (!(f_rs || f_ws || r_rs || r_ws) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk_val("start_seen", f_rs | f_ws, 1'b1);
    if (n >= 20 || sb.size() == 0) return;
    e = sb.pop_front();
    t_start = cyc;
    chk_val("f_grant_issue", f_grant, e.gf);
    chk_val("r_grant_issue", r_grant, e.gr);
    chk_val("f_wstart", f_ws, e.we);
    chk_val("f_rstart", f_rs, !e.we);
    chk_val("r_wstart", r_ws, e.we);
    chk_val("r_rstart", r_rs, !e.we);
    chk_val("f_addr", f_addr, e.af);
    chk_val("r_addr", r_addr, e.ar);
    if (e.we) begin
      chk_val("f_wdata", f_wdata, e.wdata);
      chk_val("r_wdata", r_wdata, e.wdata);
    end
    if (early_done) begin
      axi_done   = 1'b1;
      data_block = {16{32'h0BAD_0BAD}};
    end
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      axi_done = 1'b0;
      if (i == 0) begin
        chk_val("start_single", {f_rs, f_ws, r_rs, r_ws}, '0);
        req = req | set_mid;
        if (scramble) begin
          req_addr  = ~req_addr;
          req_wdata = ~req_wdata;
        end
      end
    end
    chk_val("f_grant_wait", f_grant, e.gf);
    chk_val("done_wait", {f_done, r_done}, '0);
    axi_done   = 1'b1;
    data_block = e.rd;
    @(posedge clk); #1;
    axi_done   = 1'b0;
    data_block = {16{32'h3C3C_3C3C}};
    t_done = cyc;
    if (!e.we) exp_rd = e.rd;
    chk_val("f_done", f_done, e.gf);
    chk_val("r_done", r_done, e.gr);
    chk_val("f_rdata", f_rdata, exp_rd);
    chk_val("r_rdata", r_rdata, exp_rd);
    chk_val("f_grant_resp", f_grant, e.gf);
    chk_val("r_grant_resp", r_grant, e.gr);
    chk_val("f_addr_hold", f_addr, e.af);
    chk_val("r_addr_hold", r_addr, e.ar);
    if (e.we) chk_val("f_wdata_hold", f_wdata, e.wdata);
    req = req & ~clr_mask;
    @(posedge clk); #1;
    chk_val("idle_grant_done", {f_grant, f_done, r_grant, r_done}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ts, td, ts2, td2, n;
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    axi_done = 1'b0; data_block = '0; exp_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Round robin rotates under a continuously held 3'b111; fixed keeps granting 0.
    for (int k = 0; k < N; k++) set_slot(k, 64'h4000_0015 + 64'(k) * 64'h1000, {16{32'hC0DE_0000 + k}});
    req_we = '0;
    req    = 3'b111;
    push_exp(3'b001, 3'b001, 1'b0, slot_addr(3'b001), slot_addr(3'b001), '0, {16{32'h1111_0000}});
    push_exp(3'b001, 3'b010, 1'b0, slot_addr(3'b001), slot_addr(3'b010), '0, {16{32'h1111_0001}});
    push_exp(3'b001, 3'b100, 1'b0, slot_addr(3'b001), slot_addr(3'b100), '0, {16{32'h1111_0002}});
    push_exp(3'b001, 3'b001, 1'b0, slot_addr(3'b001), slot_addr(3'b001), '0, {16{32'h1111_0003}});
    for (int t = 0; t < 4; t++) serve(2 + t, (t == 3) ? 3'b111 : 3'b000, 3'b000, 1'b0, 1'b0, ts, td);

    // Block write with operands scrambled after the grant.
    set_slot(1, 64'h0000_0000_8000_127C, {64{8'hA5}});
    req_we = 3'b010;
    req    = 3'b010;
    push_exp(3'b010, 3'b010, 1'b1, 64'h0000_0000_8000_1240, 64'h0000_0000_8000_1240,
             {64{8'hA5}}, {16{32'h5A5A_0F0F}});
    serve(3, 3'b010, 3'b000, 1'b0, 1'b1, ts, td);

    // Read with a stray done during ISSUE, real done five cycles later.
    req_we = '0;
    set_slot(2, 64'h0000_0000_2000_0ABC, '0);
    req = 3'b100;
    push_exp(3'b100, 3'b100, 1'b0, 64'h0000_0000_2000_0A80, 64'h0000_0000_2000_0A80,
             '0, {16{32'hDEAD_BEEF}});
    serve(5, 3'b100, 3'b000, 1'b1, 1'b0, ts, td);

    // Fixed-priority 3'b101; req0 returns mid-transfer and must not preempt req2.
    set_slot(0, 64'h0000_0000_0040_0107, '0);
    set_slot(2, 64'h0000_0000_0050_02FF, '0);
    req = 3'b101;
    push_exp(3'b001, 3'b001, 1'b0, slot_addr(3'b001), slot_addr(3'b001), '0, {16{32'hAAAA_0001}});
    push_exp(3'b100, 3'b100, 1'b0, slot_addr(3'b100), slot_addr(3'b100), '0, {16{32'hAAAA_0002}});
    push_exp(3'b001, 3'b001, 1'b0, slot_addr(3'b001), slot_addr(3'b001), '0, {16{32'hAAAA_0003}});
    serve(2, 3'b001, 3'b000, 1'b0, 1'b0, ts, td);
    serve(3, 3'b100, 3'b001, 1'b0, 1'b0, ts, td);
    serve(1, 3'b001, 3'b000, 1'b0, 1'b0, ts, td);

    // Same requestor back to back: reasserted in the IDLE cycle after its done.
    req = 3'b001;
    push_exp(3'b001, 3'b001, 1'b0, slot_addr(3'b001), slot_addr(3'b001), '0, {16{32'hBBBB_0001}});
    serve(2, 3'b001, 3'b000, 1'b0, 1'b0, ts, td);
    req = 3'b001;
    push_exp(3'b001, 3'b001, 1'b0, slot_addr(3'b001), slot_addr(3'b001), '0, {16{32'hBBBB_0002}});
    serve(2, 3'b001, 3'b000, 1'b0, 1'b0, ts2, td2);
    chk_val("b2b_gap", ts2 - td, 2);

    // Reset while waiting on the AXI engine; RR pointer would otherwise sit at 2.
    set_slot(1, 64'h0000_0000_3000_0444, '0);
    req = 3'b010;
    n = 0;
    while (!f_rs && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk_val("rst_pre_start", f_rs, 1'b1);
    chk_val("rst_pre_grant", {f_grant, r_grant}, 6'b010_010);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    check_zero("rst_wait");
    axi_done   = 1'b1;
    data_block = {16{32'h7777_7777}};
    @(posedge clk); #1;
    axi_done = 1'b0;
    chk_val("rst_stray_done", {f_done, r_done}, '0);
    @(posedge clk); #1;
    chk_val("rst_stray_after", {f_done, r_done, f_grant, r_grant}, '0);
    chk_val("rst_rdata_kept", f_rdata | r_rdata, '0);
    exp_rd = '0;
    req = 3'b110;
    push_exp(3'b010, 3'b010, 1'b0, slot_addr(3'b010), slot_addr(3'b010), '0, {16{32'hCCCC_0001}});
    serve(2, 3'b110, 3'b000, 1'b0, 1'b0, ts, td);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- N-requestor block-transfer arbiter between cache controllers (icache refill, dcache refill, dcache writeback, future prefetch) and the single AXI block-transfer engine.
- Replaces the fixed-priority combinational address mux.
- Adds a registered grant FSM, selectable fixed-priority or round-robin mode, per-requestor done pulses and captured read data.

Parameters:
NUM_REQ, 3, number of requestors (2..8); index 0 is highest fixed priority
ADDR_WIDTH, 64, byte address width
BLOCK_WIDTH, 512, cache block width in bits
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
i_clk  in  1  clock
i_arst  in  1  reset; synchronous, active-high (name kept per codebase)
i_req  in  NUM_REQ  per-requestor request level
i_req_we  in  NUM_REQ  1 = block write, 0 = block read
i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed byte addresses; slot k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_req_wdata  in  NUM_REQ*BLOCK_WIDTH  packed write blocks
o_req_done  out  NUM_REQ  one-cycle completion pulse to the granted requestor
o_grant  out  NUM_REQ  one-hot owner, 0 when idle
o_rdata  out  BLOCK_WIDTH  last captured read block
i_axi_done  in  1  transfer-complete pulse from the AXI engine
i_data_block  in  BLOCK_WIDTH  read block from the AXI engine
o_axi_addr  out  ADDR_WIDTH  block-aligned address
o_data_block  out  BLOCK_WIDTH  write block
o_axi_read_start  out  1  one-cycle read start pulse
o_axi_write_start  out  1  one-cycle write start pulse

Behaviour:
- Single clock i_clk; reset i_arst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; RR pointer 0.
- FSM states:
  - IDLE: if any i_req, pick a winner; latch its index, we, aligned address and wdata; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one cycle. Assert o_axi_write_start if the latched we=1, else o_axi_read_start; go to WAIT.
  - WAIT: hold until i_axi_done. On done, capture i_data_block into o_rdata only for reads; go to RESP.
  - RESP: one cycle. o_req_done[winner]=1; go to IDLE.
- Latency: i_req sampled high in IDLE at edge t → start pulse in cycle t+1. Minimum request-to-done is 3 cycles plus memory latency.
- o_grant is the one-hot winner from ISSUE through RESP inclusive; 0 in IDLE.
- o_axi_addr and o_data_block are driven from the latched values and held stable ISSUE→RESP.
- Address alignment: low log2(BLOCK_WIDTH/8) bits are forced to 0 (6 bits at default).
- Fixed mode: lowest asserted index wins.
- RR mode: search starts at the pointer. On each grant, pointer ← (winner+1) mod NUM_REQ.
- Requestor protocol: hold i_req and its operands until o_req_done is sampled high; deassert on that same edge. A request still high in the following IDLE cycle is a new request.
- Request dropped mid-transaction: the transaction completes and done is still pulsed.
- Operand changes after the grant edge are ignored.
- i_axi_done outside WAIT (IDLE/ISSUE/RESP) is ignored.
- Reset mid-operation: return to IDLE, all outputs 0, no done pulse; the in-flight transfer is abandoned.
- o_rdata is unchanged by writes and by reset-free idle periods.
- Start pulses never overlap; at most one start per transaction.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - localparams ARB_FIXED=0, ARB_RR=1
  - function block_align(addr, BLOCK_WIDTH)
- Sub-module arb_pick (combinational):
  - inputs: req vector, pointer, mode
  - output: one-hot grant plus binary index via rotate-mask priority encoder
- FSM and latches stay in mem_arb_req_arbiter's top file (mem_req_arbiter).

Test Plan:
- Fixed mode, i_req=3'b101 held: grant 3'b001 first, o_axi_read_start 1 cycle after sample; after done, grant 3'b100. Requestor 2 never preempted.
- RR mode, i_req=3'b111 continuously reasserted: grant sequence 001,010,100,001. Each requestor gets exactly one done per three transactions.
- Write: req1 we=1, addr 0x0000_0000_8000_127C, wdata pattern A5…: o_axi_addr=0x0000_0000_8000_1240, o_axi_write_start one pulse, o_data_block=A5… until RESP, o_rdata unchanged.
- Read with i_axi_done forced high during ISSUE then pulsed 5 cycles later: ISSUE-cycle done ignored; capture i_data_block=0xDEAD… only on the later pulse; o_req_done 1 cycle after.
- Reset asserted in WAIT: next cycle all outputs 0, state IDLE. A subsequent i_axi_done gives no done pulse. RR pointer is 0 (req 3'b110 → grant 3'b010).
- Same requestor back-to-back: deassert on the done edge, reassert next cycle → second start pulse exactly 2 cycles after the first done pulse.
